// File: rtl/cpu_pkg.sv
// Shared types for the execution sequencer: opcodes, FSM states, instruction field positions.
// The STEP state exists only when EXEC_FSM_STEP_EN is defined.
package cpu_pkg;

    localparam int PC_W    = 10;
    localparam int INSTR_W = 16;
    localparam int OPC_HI  = 15;
    localparam int OPC_LO  = 12;
    localparam int OFF_W   = 8;

    typedef enum logic [3:0] {
        OP_NOP  = 4'h0,
        OP_BR   = 4'h1,
        OP_BZ   = 4'h2,
        OP_HALT = 4'hF
    } opcode_t;

    typedef enum logic [3:0] {
        S_IDLE,
        S_FETCH,
        S_WAIT,
        S_DECODE,
        S_EXEC,
        S_EXWAIT,
        S_UPDATE,
`ifdef EXEC_FSM_STEP_EN
        S_STEP,
`endif
        S_HALT
    } exec_state_t;

    function automatic logic state_is_busy(exec_state_t s);
        return !((s == S_IDLE) || (s == S_HALT));
    endfunction

endpackage

// File: rtl/exec_fsm_if.sv
// PC, instruction-memory and datapath handshake bundle between the sequencer and its neighbours.
// master = sequencer side, slave = environment (PC, imem, datapath) side.
interface exec_fsm_if #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 16
);
    logic [PC_W-1:0]    pc_curr;
    logic [PC_W-1:0]    pc_inc;
    logic               pc_we;
    logic [PC_W-1:0]    pc_next;
    logic               imem_req;
    logic [PC_W-1:0]    imem_addr;
    logic               imem_valid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               ex_start;
    logic               ex_done;

    modport master (
        input  pc_curr, pc_inc, imem_valid, imem_rdata, ex_done,
        output pc_we, pc_next, imem_req, imem_addr, ex_start
    );

    modport slave (
        output pc_curr, pc_inc, imem_valid, imem_rdata, ex_done,
        input  pc_we, pc_next, imem_req, imem_addr, ex_start
    );
endinterface

// File: rtl/exec_fsm_br_target.sv
// Relative branch target: pc + sign-extended offset, wrapping modulo 2^PC_W.
// Purely combinational so later relative-jump logic can reuse it.
module br_target #(
    parameter int PC_W  = 10,
    parameter int OFF_W = 8
) (
    input  logic [PC_W-1:0]  pc,
    input  logic [OFF_W-1:0] off,
    output logic [PC_W-1:0]  target
);
    logic [PC_W-1:0] off_ext;

    for (genvar gi = 0; gi < PC_W; gi++) begin : g_ext
        if (gi < OFF_W) begin : g_lo
            assign off_ext[gi] = off[gi];
        end else begin : g_hi
            assign off_ext[gi] = off[OFF_W-1];
        end
    end

    assign target = pc + off_ext;
endmodule

// File: rtl/exec_fsm.sv
// Execution sequencer: fetch, decode control ops, dispatch data ops, commit the next PC.
// Optional single-step state enabled by defining EXEC_FSM_STEP_EN (adds the step input).
module exec_fsm #(
    parameter int PC_W    = 10,
    parameter int INSTR_W = 16
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               start,
`ifdef EXEC_FSM_STEP_EN
    input  logic               step,
`endif
    input  logic               z_flag,
    output logic [INSTR_W-1:0] ir,
    output logic               busy,
    output logic               halted,
    exec_fsm_if.master         bus
);
    import cpu_pkg::*;

    exec_state_t        state_reg;
    logic [INSTR_W-1:0] ir_reg;
    logic               pc_we_reg;
    logic [PC_W-1:0]    pc_next_reg;
    logic               imem_req_reg;
    logic [PC_W-1:0]    imem_addr_reg;
    logic               ex_start_reg;
    logic               busy_reg;
    logic               halted_reg;
    logic [PC_W-1:0]    target;
    logic [3:0]         opc;

    assign opc = ir_reg[OPC_HI:OPC_LO];

    br_target #(.PC_W(PC_W), .OFF_W(OFF_W)) u_br_target (
        .pc     (bus.pc_curr),
        .off    (ir_reg[OFF_W-1:0]),
        .target (target)
    );

    // The PC register loads pc_next at the end of UPDATE, so the refetch address is taken
    // from pc_next rather than from the still-stale pc_curr.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_reg     <= S_IDLE;
            ir_reg        <= '0;
            pc_we_reg     <= 1'b0;
            pc_next_reg   <= '0;
            imem_req_reg  <= 1'b0;
            imem_addr_reg <= '0;
            ex_start_reg  <= 1'b0;
            busy_reg      <= 1'b0;
            halted_reg    <= 1'b0;
        end else begin
            pc_we_reg    <= 1'b0;
            imem_req_reg <= 1'b0;
            ex_start_reg <= 1'b0;
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg     <= S_FETCH;
                        imem_req_reg  <= 1'b1;
                        imem_addr_reg <= bus.pc_curr;
                        busy_reg      <= 1'b1;
                    end
                end
                S_FETCH: state_reg <= S_WAIT;
                S_WAIT: begin
                    if (bus.imem_valid) begin
                        ir_reg    <= bus.imem_rdata;
                        state_reg <= S_DECODE;
                    end
                end
                S_DECODE: begin
                    case (opc)
                        OP_NOP: begin
                            state_reg   <= S_UPDATE;
                            pc_we_reg   <= 1'b1;
                            pc_next_reg <= bus.pc_inc;
                        end
                        OP_BR: begin
                            state_reg   <= S_UPDATE;
                            pc_we_reg   <= 1'b1;
                            pc_next_reg <= target;
                        end
                        OP_BZ: begin
                            state_reg   <= S_UPDATE;
                            pc_we_reg   <= 1'b1;
                            pc_next_reg <= z_flag ? target : bus.pc_inc;
                        end
                        OP_HALT: begin
                            state_reg  <= S_HALT;
                            busy_reg   <= 1'b0;
                            halted_reg <= 1'b1;
                        end
                        default: begin
                            state_reg    <= S_EXEC;
                            ex_start_reg <= 1'b1;
                        end
                    endcase
                end
                S_EXEC: state_reg <= S_EXWAIT;
                S_EXWAIT: begin
                    if (bus.ex_done) begin
                        state_reg   <= S_UPDATE;
                        pc_we_reg   <= 1'b1;
                        pc_next_reg <= bus.pc_inc;
                    end
                end
                S_UPDATE: begin
`ifdef EXEC_FSM_STEP_EN
                    state_reg <= S_STEP;
`else
                    state_reg     <= S_FETCH;
                    imem_req_reg  <= 1'b1;
                    imem_addr_reg <= pc_next_reg;
`endif
                end
`ifdef EXEC_FSM_STEP_EN
                S_STEP: begin
                    if (step) begin
                        state_reg     <= S_FETCH;
                        imem_req_reg  <= 1'b1;
                        imem_addr_reg <= pc_next_reg;
                    end
                end
`endif
                S_HALT: state_reg <= S_HALT;
                default: begin
                    state_reg  <= S_IDLE;
                    busy_reg   <= 1'b0;
                    halted_reg <= 1'b0;
                end
            endcase
        end
    end

    assign ir            = ir_reg;
    assign busy          = busy_reg;
    assign halted        = halted_reg;
    assign bus.pc_we     = pc_we_reg;
    assign bus.pc_next   = pc_next_reg;
    assign bus.imem_req  = imem_req_reg;
    assign bus.imem_addr = imem_addr_reg;
    assign bus.ex_start  = ex_start_reg;
endmodule
